// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD block-request arbiter.
//   ARB_TIMEOUT_W_DEF : default width of the acknowledge-timeout counter
//   arb_state_e       : arbiter FSM states (IDLE, REQ, XFER, DONE)
package sd_arb_pkg;

  localparam int ARB_TIMEOUT_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk_sys.
//   clk_sys : destination clock
//   reset   : synchronous active-high reset, clears both flops
//   d_i     : asynchronous input level
//   q_o     : synchronized level, two clk_sys edges behind d_i
module sync_2ff (
  input  logic clk_sys,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sd_req_arbiter.sv
// Two-requester arbiter in front of a single SD IO controller.
// Each requester strobes a sector read or write with an LBA; the request is
// held pending until served. Grants are round-robin; the granted request is
// presented as sd_rd/sd_wr + sd_lba until the (synchronized) acknowledge
// rises, then the block waits for the acknowledge to fall and pulses done.
// A counter aborts a stuck handshake with done+err.
//   clk_sys, reset            : clock, synchronous active-high reset
//   req_lba_N, req_rd_N/wr_N  : request LBA and one-cycle strobes
//   busy_N, done_N, err_N     : request status toward requester N
//   buff_wr_N, buff_din_N     : sector-buffer strobe out / data in per requester
//   sd_lba, sd_rd, sd_wr      : block request toward the IO controller
//   sd_ack                    : IO controller acknowledge (foreign clock domain)
//   sd_buff_wr, sd_buff_din   : sector-buffer strobe in / routed data out
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_W = ARB_TIMEOUT_W_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] req_lba_0,
  input  logic [31:0] req_lba_1,
  input  logic        req_rd_0,
  input  logic        req_rd_1,
  input  logic        req_wr_0,
  input  logic        req_wr_1,
  output logic        busy_0,
  output logic        busy_1,
  output logic        done_0,
  output logic        done_1,
  output logic        err_0,
  output logic        err_1,
  output logic        buff_wr_0,
  output logic        buff_wr_1,
  input  logic [7:0]  buff_din_0,
  input  logic [7:0]  buff_din_1,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  localparam logic [TIMEOUT_W-1:0] TMO_ONE = 1;

  arb_state_e           state_q;
  logic [1:0]           pend_q;
  logic [1:0]           dir_wr_q;
  logic [31:0]          lba0_q;
  logic [31:0]          lba1_q;
  logic                 owner_q;
  logic                 last_q;
  logic                 sd_rd_q;
  logic                 sd_wr_q;
  logic [31:0]          sd_lba_q;
  logic                 done_q;
  logic                 err_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_d;
  logic                 tmo_hit;
  logic                 ack_s;
  logic                 gnt;
  logic                 gnt_wr;
  logic [31:0]          gnt_lba;
  logic                 in_xfer;

  sync_2ff u_ack_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d_i     (sd_ack),
    .q_o     (ack_s)
  );

  // Request capture. A strobe is only taken while the requester is idle, so
  // the owner cannot re-arm itself during DONE (pending is still set there).
  // Write wins when rd and wr strobe together.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q   <= 2'b00;
      dir_wr_q <= 2'b00;
    end else begin
      if (!pend_q[0] && (req_rd_0 || req_wr_0)) begin
        pend_q[0]   <= 1'b1;
        dir_wr_q[0] <= req_wr_0;
      end else if (state_q == ST_DONE && !owner_q) begin
        pend_q[0] <= 1'b0;
      end
      if (!pend_q[1] && (req_rd_1 || req_wr_1)) begin
        pend_q[1]   <= 1'b1;
        dir_wr_q[1] <= req_wr_1;
      end else if (state_q == ST_DONE && owner_q) begin
        pend_q[1] <= 1'b0;
      end
    end
  end

  // LBA is data: captured with its strobe, no reset needed.
  always_ff @(posedge clk_sys) begin
    if (!pend_q[0] && (req_rd_0 || req_wr_0)) lba0_q <= req_lba_0;
    if (!pend_q[1] && (req_rd_1 || req_wr_1)) lba1_q <= req_lba_1;
  end

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    gnt = pend_q[1];
    if (pend_q == 2'b11) gnt = ~last_q;
    gnt_wr  = gnt ? dir_wr_q[1] : dir_wr_q[0];
    gnt_lba = gnt ? lba1_q : lba0_q;
  end

  // The counter leaves REQ/XFER when its next value reaches all-ones, so the
  // handshake is given exactly 2^TIMEOUT_W-1 cycles and never wraps.
  assign tmo_d   = tmo_q + TMO_ONE;
  assign tmo_hit = (tmo_d == '1);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      sd_lba_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            owner_q  <= gnt;
            sd_lba_q <= gnt_lba;
            sd_rd_q  <= ~gnt_wr;
            sd_wr_q  <= gnt_wr;
            tmo_q    <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (tmo_hit) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_d;
            if (ack_s) begin
              sd_rd_q <= 1'b0;
              sd_wr_q <= 1'b0;
              state_q <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (tmo_hit) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_DONE: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_xfer = (state_q == ST_REQ) || (state_q == ST_XFER);

  assign busy_0      = pend_q[0];
  assign busy_1      = pend_q[1];
  assign done_0      = done_q & ~owner_q;
  assign done_1      = done_q &  owner_q;
  assign err_0       = err_q  & ~owner_q;
  assign err_1       = err_q  &  owner_q;
  assign buff_wr_0   = in_xfer & ~owner_q & sd_buff_wr;
  assign buff_wr_1   = in_xfer &  owner_q & sd_buff_wr;
  assign sd_buff_din = owner_q ? buff_din_1 : buff_din_0;
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;

endmodule
